// File: rtl/ldm_pkg.sv
// ============================================================================
//  Module      : ldm_pkg
//  Description : Shared types and helpers for the block-transfer sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ldm_pkg;

    localparam int c_MAX_NREG = 256;

    // Encoded as {P,U}
    typedef enum logic [1:0] {
        DA = 2'b00,
        IA = 2'b01,
        DB = 2'b10,
        IB = 2'b11
    } am_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        WBACK = 2'd2
    } seq_state_e;

    // Callers zero-extend their register list to c_MAX_NREG bits.
    function automatic logic [8:0] popcount(input logic [c_MAX_NREG-1:0] v);
        logic [8:0] cnt;
        cnt = '0;
        for (int i = 0; i < c_MAX_NREG; i++) begin
            cnt = cnt + 9'(v[i]);
        end
        return cnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ldm_sequencer_if.sv
// ============================================================================
//  Module      : ldm_sequencer_if
//  Description : Decode-side instruction inputs and uop outputs of the sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ldm_sequencer_if
    import ldm_pkg::*;
#(
    parameter int NREG   = 16,
    parameter int RA_W   = $clog2(NREG),
    parameter int ADDR_W = 32
);
    logic              start;
    logic [NREG-1:0]   reglist;
    logic [1:0]        mode;
    logic              wb;
    logic              load;
    logic [RA_W-1:0]   base_rn;
    logic              stall_in;
    logic              flush;

    logic              uop_valid;
    logic [RA_W-1:0]   uop_reg;
    logic [ADDR_W-1:0] uop_offset;
    logic              uop_wb;
    logic              uop_last;
    logic              stall_fd;
    logic              busy;

    modport master (
        output start, reglist, mode, wb, load, base_rn, stall_in, flush,
        input  uop_valid, uop_reg, uop_offset, uop_wb, uop_last, stall_fd, busy
    );

    modport slave (
        input  start, reglist, mode, wb, load, base_rn, stall_in, flush,
        output uop_valid, uop_reg, uop_offset, uop_wb, uop_last, stall_fd, busy
    );

endinterface

`default_nettype wire

// File: rtl/lsb_prio_enc.sv
// ============================================================================
//  Module      : lsb_prio_enc
//  Description : Index of the lowest set bit plus an any-bit-set flag.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsb_prio_enc #(
    parameter int NREG = 16,
    parameter int RA_W = $clog2(NREG)
) (
    input  logic [NREG-1:0] i_vec,
    output logic [RA_W-1:0] o_idx,
    output logic            o_any
);

    // Scanning downwards lets the lowest set bit overwrite any higher one.
    always_comb begin
        o_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = RA_W'(i);
            end
        end
    end

    assign o_any = |i_vec;

endmodule

`default_nettype wire

// File: rtl/ldm_sequencer.sv
// ============================================================================
//  Module      : ldm_sequencer
//  Description : Expands an LDM/STM register list into per-register uops plus
//                an optional base-writeback uop, holding decode meanwhile.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ldm_sequencer
    import ldm_pkg::*;
#(
    parameter int NREG   = 16,
    parameter int RA_W   = $clog2(NREG),
    parameter int ADDR_W = 32,
    parameter int WORD_B = 4
) (
    input  logic           clk,
    input  logic           rst,
    ldm_sequencer_if.slave bus
);

    localparam int                c_NB_W = RA_W + 1 + $clog2(WORD_B);
    localparam logic [ADDR_W-1:0] c_STEP = ADDR_W'(WORD_B);

    seq_state_e        r_state;
    logic [NREG-1:0]   r_mask;
    logic [ADDR_W-1:0] r_offset;
    logic              r_up;
    logic              r_wb_eff;
    logic [RA_W-1:0]   r_base_rn;
    logic [RA_W:0]     r_n;

    seq_state_e        w_state_nxt;
    logic [NREG-1:0]   w_mask_nxt;
    logic [ADDR_W-1:0] w_offset_nxt;
    logic              w_up_nxt;
    logic              w_wb_eff_nxt;
    logic [RA_W-1:0]   w_base_nxt;
    logic [RA_W:0]     w_n_nxt;

    logic              w_idle;
    logic [NREG-1:0]   w_enc_in;
    logic [RA_W-1:0]   w_idx;
    logic              w_any;
    logic [NREG-1:0]   w_rest;
    logic              w_more;

    logic [c_MAX_NREG-1:0] w_list_ext;
    logic [RA_W:0]         w_n_cur;
    logic [c_NB_W-1:0]     w_nb_cur;
    logic [c_NB_W-1:0]     w_nb_lat;
    logic [ADDR_W-1:0]     w_nb_cur_ext;
    logic [ADDR_W-1:0]     w_nb_lat_ext;
    logic [ADDR_W-1:0]     w_base_off;
    logic                  w_wb_eff_cur;
    logic                  w_launch;

    logic              w_uop_valid;
    logic [RA_W-1:0]   w_uop_reg;
    logic [ADDR_W-1:0] w_uop_offset;
    logic              w_uop_wb;
    logic              w_uop_last;

    // One encoder serves both the incoming list and the remaining mask.
    assign w_idle   = (r_state == IDLE);
    assign w_enc_in = w_idle ? bus.reglist : r_mask;

    lsb_prio_enc #(
        .NREG (NREG),
        .RA_W (RA_W)
    ) u_enc (
        .i_vec (w_enc_in),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_rest = w_enc_in & ~(NREG'(1) << w_idx);
    assign w_more = |w_rest;

    always_comb begin
        w_list_ext             = '0;
        w_list_ext[NREG-1:0]   = bus.reglist;
    end

    assign w_n_cur  = (RA_W + 1)'(popcount(w_list_ext));
    assign w_nb_cur = c_NB_W'(w_n_cur) * c_NB_W'(WORD_B);
    assign w_nb_lat = c_NB_W'(r_n) * c_NB_W'(WORD_B);

    // Byte counts are magnitudes: zero-extend so N == NREG never turns negative.
    assign w_nb_cur_ext = ADDR_W'(w_nb_cur);
    assign w_nb_lat_ext = ADDR_W'(w_nb_lat);

    always_comb begin
        w_base_off = '0;
        unique case (am_e'(bus.mode))
            IA:      w_base_off = '0;
            IB:      w_base_off = c_STEP;
            DA:      w_base_off = c_STEP - w_nb_cur_ext;
            DB:      w_base_off = -w_nb_cur_ext;
            default: w_base_off = '0;
        endcase
    end

    // A loaded base overrides writeback; a stored base still writes back.
    assign w_wb_eff_cur = bus.wb & ~(bus.load & bus.reglist[bus.base_rn]);
    assign w_launch     = w_idle & bus.start & w_any & ~bus.flush & rst;

    always_comb begin
        w_state_nxt  = r_state;
        w_mask_nxt   = r_mask;
        w_offset_nxt = r_offset;
        w_up_nxt     = r_up;
        w_wb_eff_nxt = r_wb_eff;
        w_base_nxt   = r_base_rn;
        w_n_nxt      = r_n;
        w_uop_valid  = 1'b0;
        w_uop_reg    = '0;
        w_uop_offset = '0;
        w_uop_wb     = 1'b0;
        w_uop_last   = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_launch) begin
                    w_uop_valid  = 1'b1;
                    w_uop_reg    = w_idx;
                    w_uop_offset = w_base_off;
                    w_uop_last   = ~w_more & ~w_wb_eff_cur;
                    w_mask_nxt   = w_rest;
                    w_offset_nxt = w_base_off + c_STEP;
                    w_up_nxt     = bus.mode[0];
                    w_wb_eff_nxt = w_wb_eff_cur;
                    w_base_nxt   = bus.base_rn;
                    w_n_nxt      = w_n_cur;
                    if (w_more) begin
                        w_state_nxt = XFER;
                    end else if (w_wb_eff_cur) begin
                        w_state_nxt = WBACK;
                    end
                end
            end
            XFER: begin
                w_uop_valid  = 1'b1;
                w_uop_reg    = w_idx;
                w_uop_offset = r_offset;
                w_uop_last   = ~w_more & ~r_wb_eff;
                w_mask_nxt   = w_rest;
                w_offset_nxt = r_offset + c_STEP;
                if (!w_more) begin
                    w_state_nxt = r_wb_eff ? WBACK : IDLE;
                end
            end
            WBACK: begin
                w_uop_valid  = 1'b1;
                w_uop_wb     = 1'b1;
                w_uop_reg    = r_base_rn;
                w_uop_offset = r_up ? w_nb_lat_ext : -w_nb_lat_ext;
                w_uop_last   = 1'b1;
                w_state_nxt  = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Flush outranks stall; a stall freezes every piece of sequencer state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_mask    <= '0;
            r_offset  <= '0;
            r_up      <= 1'b0;
            r_wb_eff  <= 1'b0;
            r_base_rn <= '0;
            r_n       <= '0;
        end else if (bus.flush) begin
            r_state <= IDLE;
            r_mask  <= '0;
        end else if (!bus.stall_in) begin
            r_state   <= w_state_nxt;
            r_mask    <= w_mask_nxt;
            r_offset  <= w_offset_nxt;
            r_up      <= w_up_nxt;
            r_wb_eff  <= w_wb_eff_nxt;
            r_base_rn <= w_base_nxt;
            r_n       <= w_n_nxt;
        end
    end

    assign bus.uop_valid  = w_uop_valid;
    assign bus.uop_reg    = w_uop_reg;
    assign bus.uop_offset = w_uop_offset;
    assign bus.uop_wb     = w_uop_wb;
    assign bus.uop_last   = w_uop_last;
    assign bus.stall_fd   = w_uop_valid & ~w_uop_last;
    assign bus.busy       = ~w_idle;

endmodule

`default_nettype wire

// File: tb/tb_ldm_sequencer.sv
// ============================================================================
//  Module      : tb_ldm_sequencer
//  Description : Self-checking bench for ldm_sequencer (table, directed, random).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ldm_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ldm_sequencer_if #(.NREG(16), .RA_W(4), .ADDR_W(32)) bus ();

    ldm_sequencer #(
        .NREG   (16),
        .RA_W   (4),
        .ADDR_W (32),
        .WORD_B (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  r;
        logic [31:0] off;
        logic        wbf;
        logic        last;
    } uop_t;

    uop_t exp_q[$];

    typedef struct {
        logic [15:0]      list;
        logic [1:0]       mode;
        logic             w;
        logic             ld;
        logic [3:0]       base;
        int               n;
        logic [5:0][3:0]  regs;
        logic [5:0][31:0] offs;
        logic             has_wb;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [15:0] l, input logic [1:0] m,
                         input logic w, input logic ld, input logic [3:0] b,
                         input logic st, input logic fl);
        bus.start    = s;
        bus.reglist  = l;
        bus.mode     = m;
        bus.wb       = w;
        bus.load     = ld;
        bus.base_rn  = b;
        bus.stall_in = st;
        bus.flush    = fl;
    endtask

    task automatic expect_uop(input string nm, input logic v, input logic [3:0] r,
                              input logic [31:0] off, input logic wbf, input logic last,
                              input logic bsy);
        @(negedge clk);
        chk({nm, ".valid"}, 64'(bus.uop_valid), 64'(v));
        if (v) begin
            chk({nm, ".reg"},    64'(bus.uop_reg),    64'(r));
            chk({nm, ".offset"}, 64'(bus.uop_offset), 64'(off));
            chk({nm, ".wb"},     64'(bus.uop_wb),     64'(wbf));
            chk({nm, ".last"},   64'(bus.uop_last),   64'(last));
        end
        chk({nm, ".stall_fd"}, 64'(bus.stall_fd), 64'(v & ~last));
        chk({nm, ".busy"},     64'(bus.busy),     64'(bsy));
    endtask

    // Reference: registers ascend from the lowest address of the block.
    function automatic void model(input logic [15:0] list, input logic [1:0] mode,
                                  input logic w, input logic ld, input logic [3:0] base);
        int n, first, k;
        logic up, pre;
        exp_q.delete();
        n = $countones(list);
        if (n == 0) return;
        up    = mode[0];
        pre   = mode[1];
        first = (up ? 0 : -4 * n) + ((pre == up) ? 4 : 0);
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                exp_q.push_back('{r: 4'(i), off: 32'(first + 4 * k), wbf: 1'b0, last: 1'b0});
                k++;
            end
        end
        if (w && !(ld && list[base]))
            exp_q.push_back('{r: base, off: 32'(up ? 4 * n : -4 * n), wbf: 1'b1, last: 1'b0});
        exp_q[exp_q.size() - 1].last = 1'b1;
    endfunction

    // Plays exp_q out; after the first uop is accepted the decode inputs turn to noise.
    task automatic run_queue(input logic [15:0] list, input logic [1:0] mode, input logic w,
                             input logic ld, input logic [3:0] base, input int stall_pct,
                             input string nm);
        bit   started = 1'b0;
        int   cyc     = 0;
        logic stl;
        if (exp_q.size() == 0) begin
            drive(1'b1, list, mode, w, ld, base, 1'b0, 1'b0);
            expect_uop({nm, ".empty"}, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
            tick();
            drive(1'b0, list, mode, w, ld, base, 1'b0, 1'b0);
            expect_uop({nm, ".empty_after"}, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
            tick();
            return;
        end
        while (exp_q.size() > 0 && cyc < 200) begin
            stl = ($urandom_range(0, 99) < stall_pct);
            if (started)
                drive(1'b0, 16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                      4'($urandom), stl, 1'b0);
            else
                drive(1'b1, list, mode, w, ld, base, stl, 1'b0);
            expect_uop(nm, 1'b1, exp_q[0].r, exp_q[0].off, exp_q[0].wbf, exp_q[0].last, started);
            if (!stl) begin
                void'(exp_q.pop_front());
                started = 1'b1;
            end
            tick();
            cyc++;
        end
        chk({nm, ".budget"}, 64'(exp_q.size()), 64'd0);
        drive(1'b0, 16'd0, 2'b01, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        expect_uop({nm, ".idle"}, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic run_instr(input logic [15:0] list, input logic [1:0] mode, input logic w,
                             input logic ld, input logic [3:0] base, input int stall_pct,
                             input string nm);
        model(list, mode, w, ld, base);
        run_queue(list, mode, w, ld, base, stall_pct, nm);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{16'h000F, 2'b01, 1'b1, 1'b0, 4'd0, 5,
                   {4'd0, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0},
                   {32'd0, 32'd16, 32'd12, 32'd8, 32'd4, 32'd0}, 1'b1};
        tbl[1] = '{16'h8001, 2'b10, 1'b0, 1'b0, 4'd0, 2,
                   {4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 4'd0},
                   {32'd0, 32'd0, 32'd0, 32'd0, -32'sd4, -32'sd8}, 1'b0};
        tbl[2] = '{16'h0006, 2'b00, 1'b1, 1'b1, 4'd2, 2,
                   {4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd1},
                   {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, -32'sd4}, 1'b0};
        tbl[3] = '{16'h0006, 2'b00, 1'b1, 1'b0, 4'd2, 3,
                   {4'd0, 4'd0, 4'd0, 4'd2, 4'd2, 4'd1},
                   {32'd0, 32'd0, 32'd0, -32'sd8, 32'd0, -32'sd4}, 1'b1};
        tbl[4] = '{16'h0024, 2'b11, 1'b1, 1'b1, 4'd0, 3,
                   {4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd2},
                   {32'd0, 32'd0, 32'd0, 32'd8, 32'd8, 32'd4}, 1'b1};

        // Reset: every output low.
        rst = 1'b0;
        drive(1'b0, 16'd0, 2'b01, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tick();
            @(negedge clk);
            chk("reset.valid",    64'(bus.uop_valid),  64'd0);
            chk("reset.reg",      64'(bus.uop_reg),    64'd0);
            chk("reset.offset",   64'(bus.uop_offset), 64'd0);
            chk("reset.wb",       64'(bus.uop_wb),     64'd0);
            chk("reset.last",     64'(bus.uop_last),   64'd0);
            chk("reset.stall_fd", 64'(bus.stall_fd),   64'd0);
            chk("reset.busy",     64'(bus.busy),       64'd0);
        end
        tick();
        rst = 1'b1;

        // Table of fully worked instructions.
        for (int t = 0; t < 5; t++) begin
            exp_q.delete();
            for (int k = 0; k < tbl[t].n; k++) begin
                exp_q.push_back('{r: tbl[t].regs[k], off: tbl[t].offs[k],
                                  wbf: tbl[t].has_wb && (k == tbl[t].n - 1),
                                  last: (k == tbl[t].n - 1)});
            end
            run_queue(tbl[t].list, tbl[t].mode, tbl[t].w, tbl[t].ld, tbl[t].base, 0,
                      $sformatf("table%0d", t));
        end

        // Stall during the second uop: r1 held, then r1, then r2.
        drive(1'b1, 16'h0007, 2'b01, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        expect_uop("stall.r0", 1'b1, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 16'h0007, 2'b01, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
            expect_uop("stall.r1_held", 1'b1, 4'd1, 32'd4, 1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 16'h0007, 2'b01, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        expect_uop("stall.r1", 1'b1, 4'd1, 32'd4, 1'b0, 1'b0, 1'b1);
        tick();
        expect_uop("stall.r2", 1'b1, 4'd2, 32'd8, 1'b0, 1'b1, 1'b1);
        tick();
        expect_uop("stall.idle", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();

        // Flush in the second cycle, then a clean restart.
        drive(1'b1, 16'h00F0, 2'b01, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        expect_uop("flush.r4", 1'b1, 4'd4, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h00F0, 2'b01, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("flush.busy_in_flush", 64'(bus.busy), 64'd1);
        tick();
        drive(1'b0, 16'h00F0, 2'b01, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        expect_uop("flush.after", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        run_instr(16'h0003, 2'b01, 1'b0, 1'b0, 4'd0, 0, "flush.restart");

        // A start arriving with flush is dropped.
        drive(1'b1, 16'h000F, 2'b01, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        expect_uop("flush_start.same", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h000F, 2'b01, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        expect_uop("flush_start.next", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();

        // Reset in the middle of a sequence.
        drive(1'b1, 16'h0F0F, 2'b01, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        expect_uop("midreset.r0", 1'b1, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0F0F, 2'b01, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        expect_uop("midreset.after", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();

        // Randomised instructions with random stalls against the model.
        for (int it = 0; it < 60; it++) begin
            logic [15:0] l;
            int          sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)      l = 16'h0000;
            else if (sel == 1) l = 16'hFFFF;
            else               l = 16'($urandom) & 16'($urandom);
            run_instr(l, 2'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 30,
                      $sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
